// File: rtl/rtc_bus_cycle_ctrl.sv
// rtl/rtc_bus_cycle_ctrl.sv - RTC multiplexed AD bus cycle sequencer (address cycle, gap, data cycle)
module rtc_bus_cycle_ctrl #(
    parameter int T_SU  = 2,
    parameter int T_PW  = 5,
    parameter int T_H   = 2,
    parameter int T_GAP = 3
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic       we,
    input  logic [7:0] addr,
    input  logic [7:0] wdata,
    output logic       busy,
    output logic       done,
    output logic [7:0] rdata,
    output logic       cs_n,
    output logic       rd_n,
    output logic       wr_n,
    output logic       ad_sel,
    output logic [7:0] sig_out,
    output logic       buffer_activo,
    input  logic [7:0] sig_in
);

    typedef enum logic [3:0] {
        IDLE, ADDR_SU, ADDR_PW, ADDR_H, GAP, DATA_SU, DATA_PW, DATA_H, DONE
    } state_t;

    state_t     state, state_nxt;
    logic [7:0] cnt, cnt_nxt;
    logic       we_r, we_nxt;
    logic [7:0] addr_r, addr_nxt;
    logic [7:0] wdata_r, wdata_nxt;
    logic       is_addr, is_data;
    logic [7:0] byte_nxt;

    // Down-counter preload for a phase: the phase lasts (preload + 1) cycles.
    function automatic logic [7:0] phase_len(input state_t s);
        case (s)
            ADDR_SU, DATA_SU: phase_len = 8'(T_SU - 1);
            ADDR_PW, DATA_PW: phase_len = 8'(T_PW - 1);
            ADDR_H,  DATA_H:  phase_len = 8'(T_H - 1);
            GAP:              phase_len = 8'(T_GAP - 1);
            default:          phase_len = 8'd0;
        endcase
    endfunction

    // Next-state, counter and request-latch logic; outputs are decoded from the next state
    // so every bus-side pin comes straight out of a flop.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        we_nxt    = we_r;
        addr_nxt  = addr_r;
        wdata_nxt = wdata_r;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = ADDR_SU;
                    cnt_nxt   = phase_len(ADDR_SU);
                    we_nxt    = we;
                    addr_nxt  = addr;
                    wdata_nxt = wdata;
                end
            end
            DONE: state_nxt = IDLE;
            default: begin
                if (cnt != 8'd0) begin
                    cnt_nxt = cnt - 8'd1;
                end else begin
                    state_nxt = state_t'(state + 4'd1);
                    cnt_nxt   = phase_len(state_t'(state + 4'd1));
                end
            end
        endcase
        is_addr  = (state_nxt == ADDR_SU) || (state_nxt == ADDR_PW) || (state_nxt == ADDR_H);
        is_data  = (state_nxt == DATA_SU) || (state_nxt == DATA_PW) || (state_nxt == DATA_H);
        byte_nxt = is_addr ? addr_nxt : ((is_data && we_nxt) ? wdata_nxt : 8'h00);
    end

    // Sequencer state and registered bus/handshake outputs; rdata captured while rd_n is still low.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            cnt           <= 8'd0;
            we_r          <= 1'b0;
            addr_r        <= 8'h00;
            wdata_r       <= 8'h00;
            cs_n          <= 1'b1;
            rd_n          <= 1'b1;
            wr_n          <= 1'b1;
            ad_sel        <= 1'b0;
            buffer_activo <= 1'b0;
            sig_out       <= 8'h00;
            busy          <= 1'b0;
            done          <= 1'b0;
            rdata         <= 8'h00;
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            we_r          <= we_nxt;
            addr_r        <= addr_nxt;
            wdata_r       <= wdata_nxt;
            cs_n          <= !(is_addr || is_data);
            wr_n          <= !((state_nxt == ADDR_PW) || ((state_nxt == DATA_PW) && we_nxt));
            rd_n          <= !((state_nxt == DATA_PW) && !we_nxt);
            ad_sel        <= is_data;
            buffer_activo <= is_addr || (is_data && we_nxt);
            sig_out       <= byte_nxt;
            busy          <= is_addr || is_data || (state_nxt == GAP);
            done          <= (state_nxt == DONE);
            if ((state == DATA_PW) && (cnt == 8'd0) && !we_r) begin
                rdata <= sig_in;
            end
        end
    end

endmodule

// File: tb/tb_rtc_bus_cycle_ctrl.sv
// tb/tb_rtc_bus_cycle_ctrl.sv - scoreboard bench for rtc_bus_cycle_ctrl with a transaction-level model
module tb_rtc_bus_cycle_ctrl;

    localparam int SU = 2, PW = 5, HO = 2, GP = 3;
    localparam int LAT = 2 * (SU + PW + HO) + GP;
    localparam int CSL = 2 * (SU + PW + HO);

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0, we = 1'b0;
    logic [7:0] addr = 8'h00, wdata = 8'h00;
    logic       busy, done, cs_n, rd_n, wr_n, ad_sel, buffer_activo;
    logic [7:0] rdata, sig_out, sig_in;
    logic [7:0] cur_rv = 8'h00;

    logic       start_b = 1'b0, we_b = 1'b0;
    logic [7:0] addr_b = 8'h00, wdata_b = 8'h00;
    logic       busy_b, done_b, cs_n_b, rd_n_b, wr_n_b, ad_sel_b, buffer_activo_b;
    logic [7:0] rdata_b, sig_out_b, sig_in_b;

    always #5 clk = ~clk;

    // AD bus model: the RTC only drives its value while RD is asserted.
    assign sig_in   = rd_n   ? 8'hFF : cur_rv;
    assign sig_in_b = rd_n_b ? 8'hFF : 8'h3C;

    rtc_bus_cycle_ctrl dut (
        .clk(clk), .reset_n(reset_n), .start(start), .we(we), .addr(addr), .wdata(wdata),
        .busy(busy), .done(done), .rdata(rdata), .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n),
        .ad_sel(ad_sel), .sig_out(sig_out), .buffer_activo(buffer_activo), .sig_in(sig_in)
    );

    rtc_bus_cycle_ctrl #(.T_SU(1), .T_PW(1), .T_H(1), .T_GAP(1)) dut_b (
        .clk(clk), .reset_n(reset_n), .start(start_b), .we(we_b), .addr(addr_b), .wdata(wdata_b),
        .busy(busy_b), .done(done_b), .rdata(rdata_b), .cs_n(cs_n_b), .rd_n(rd_n_b), .wr_n(wr_n_b),
        .ad_sel(ad_sel_b), .sig_out(sig_out_b), .buffer_activo(buffer_activo_b), .sig_in(sig_in_b)
    );

    typedef struct {
        bit       w;
        bit [7:0] a;
        bit [7:0] d;
        bit [7:0] r;
        int       e0;
    } exp_t;

    exp_t     q[$];
    int       checks = 0, errors = 0;
    int       cyc = 0;
    int       free_edge = 0;
    bit [7:0] rdata_model = 8'h00;
    int       cs_cnt, aw_cnt, dw_cnt, rd_cnt, busy_cnt, bad_cnt;

    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string nm, input int act, input int req);
        checks = checks + 1;
        if (act != req) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", nm, act, act, req, req, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_trk();
        cs_cnt = 0; aw_cnt = 0; dw_cnt = 0; rd_cnt = 0; busy_cnt = 0; bad_cnt = 0;
    endtask

    // Issue one request at the earliest edge the sequencer can accept it and record the expectation.
    task automatic issue(input bit w, input bit [7:0] a, input bit [7:0] d, input bit [7:0] v, output int e0);
        exp_t e;
        while (cyc + 1 < free_edge) tick();
        start = 1'b1; we = w; addr = a; wdata = d;
        cur_rv = v;
        e0 = cyc + 1;
        if (!w) rdata_model = v;
        e.w = w; e.a = a; e.d = d; e.r = rdata_model; e.e0 = e0;
        q.push_back(e);
        free_edge = e0 + LAT + 2;
        tick();
        start = 1'b0; we = ~w; addr = ~a; wdata = ~d;
    endtask

    task automatic wait_drain(input string nm);
        int n = 0;
        while (q.size() != 0 && n < 300) begin
            tick();
            n++;
        end
        chk(nm, q.size(), 0);
    endtask

    // Monitor: accumulates bus observations per transaction and checks them when done pulses.
    initial clear_trk();
    always @(negedge clk) begin
        if (!reset_n) begin
            clear_trk();
        end else begin
            chk("no_drive_while_rd", int'(buffer_activo && !rd_n), 0);
            chk("strobes_exclusive", int'(!rd_n && !wr_n), 0);
            if (q.size() == 0) begin
                chk("idle_quiet", int'(!cs_n || !rd_n || !wr_n || buffer_activo || busy || done), 0);
            end else begin
                if (!cs_n) cs_cnt++;
                if (busy) busy_cnt++;
                if (!wr_n && !ad_sel) begin
                    aw_cnt++;
                    if (sig_out != q[0].a || !buffer_activo) bad_cnt++;
                end
                if (!wr_n && ad_sel) begin
                    dw_cnt++;
                    if (sig_out != q[0].d || !buffer_activo) bad_cnt++;
                end
                if (!rd_n) begin
                    rd_cnt++;
                    if (!ad_sel || cs_n) bad_cnt++;
                end
                if (!cs_n && ad_sel && !q[0].w && buffer_activo) bad_cnt++;
                if (done) begin
                    chk("done_latency", cyc, q[0].e0 + LAT);
                    chk("rdata", int'(rdata), int'(q[0].r));
                    chk("cs_low_cycles", cs_cnt, CSL);
                    chk("busy_cycles", busy_cnt, LAT);
                    chk("addr_wr_cycles", aw_cnt, PW);
                    chk("data_wr_cycles", dw_cnt, q[0].w ? PW : 0);
                    chk("data_rd_cycles", rd_cnt, q[0].w ? 0 : PW);
                    chk("bus_values", bad_cnt, 0);
                    chk("busy_in_done", int'(busy), 0);
                    void'(q.pop_front());
                    clear_trk();
                end
            end
        end
    end

    initial begin
        int e0;
        int e0b, done_cyc, ndone, rdl;

        // Reset held: idle pin levels on both instances.
        tick(); tick(); tick();
        chk("rst_cs_n", int'(cs_n), 1);
        chk("rst_rd_n", int'(rd_n), 1);
        chk("rst_wr_n", int'(wr_n), 1);
        chk("rst_buf", int'(buffer_activo), 0);
        chk("rst_rdata", int'(rdata), 0);
        chk("rst_busy_done", int'(busy || done), 0);
        chk("rst_b_strobes", int'({cs_n_b, rd_n_b, wr_n_b, buffer_activo_b}), 4'b1110);
        reset_n = 1'b1;
        free_edge = cyc + 1;
        repeat (10) tick();

        // Directed write, with a second start inside the transaction that must be ignored.
        issue(1'b1, 8'h21, 8'h45, 8'h00, e0);
        while (cyc < e0 + 4) tick();
        start = 1'b1; we = 1'b0; addr = 8'h99;
        tick();
        start = 1'b0;
        wait_drain("drain_write");

        // Directed read then write: rdata must survive the write.
        issue(1'b0, 8'h23, 8'h00, 8'hA7, e0);
        issue(1'b1, 8'h24, 8'h5A, 8'h00, e0);
        wait_drain("drain_rd_wr");
        chk("rdata_after_write", int'(rdata), 8'hA7);

        // Back-to-back pair at the earliest acceptable edge.
        issue(1'b1, 8'h30, 8'h31, 8'h00, e0);
        issue(1'b0, 8'h32, 8'h00, 8'h6E, e0);
        wait_drain("drain_b2b");

        // Reset asserted in the middle of the data strobe of a write.
        issue(1'b1, 8'h40, 8'h41, 8'h00, e0);
        while (cyc < e0 + SU + PW + HO + GP + SU + 2) tick();
        #1;
        chk("mid_wr_n_low", int'(wr_n), 0);
        reset_n = 1'b0;
        q.delete();
        rdata_model = 8'h00;
        #1;
        chk("mid_rst_strobes", int'({cs_n, rd_n, wr_n}), 3'b111);
        chk("mid_rst_buf", int'(buffer_activo), 0);
        chk("mid_rst_rdata", int'(rdata), 0);
        tick(); tick();
        reset_n = 1'b1;
        free_edge = cyc + 1;
        tick();
        issue(1'b1, 8'h42, 8'h43, 8'h00, e0);
        issue(1'b0, 8'h44, 8'h00, 8'hC3, e0);
        wait_drain("drain_after_rst");

        // Randomized traffic with random idle spacing (including none).
        for (int i = 0; i < 20; i++) begin
            repeat ($urandom_range(0, 3)) tick();
            issue(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 8'($urandom), e0);
        end
        wait_drain("drain_random");

        // Minimum-parameter instance: single-cycle phases, read.
        tick();
        start_b = 1'b1; we_b = 1'b0; addr_b = 8'h55;
        e0b = cyc + 1;
        tick();
        start_b = 1'b0;
        done_cyc = -1; ndone = 0; rdl = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (!rd_n_b) rdl++;
            if (!rd_n_b && buffer_activo_b) rdl = rdl + 100;
            if (done_b) begin
                done_cyc = cyc;
                ndone++;
            end
        end
        chk("b_done_latency", done_cyc, e0b + 7);
        chk("b_done_count", ndone, 1);
        chk("b_rd_low_cycles", rdl, 1);
        chk("b_rdata", int'(rdata_b), 8'h3C);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
